sort_pipe: RTL and testbench
============================

SORT_PIPE -- requirements
Module: sort_pipe

Interface
REQ-001 SHALL have parameter DW, default 8, meaning width of one unsigned element.
REQ-002 SHALL have parameter N, default 4, meaning elements per vector; legal values 2, 4, 8, 16.
REQ-003 SHALL have ports, with clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block accepts input.
- in_desc  in  1  sort order: 0 ascending, 1 descending.
- in_data  in  N*DW  lane i at bits [i*DW +: DW].
- out_valid  out  1  sorted vector valid.
- out_ready  in  1  consumer accepts output.
- out_data  out  N*DW  sorted vector; lane 0 is the minimum when ascending, the maximum when descending.
- out_tag  out  N*log2(N)  original lane index of each output lane; present only with SORT_TAG_EN.
REQ-004 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-005 SHALL implement a bitonic sorting network of S = log2(N)*(log2(N)+1)/2 register stages; S = 3 for N = 4 and S = 10 for N = 16.
REQ-006 Each compare-and-swap SHALL use unsigned compare; on equal values it SHALL NOT swap.
REQ-007 A vector SHALL transfer in when in_valid && in_ready, and out when out_valid && out_ready.
REQ-008 Pipeline advance SHALL be adv = !out_valid || out_ready; all stages shift together when adv = 1, and hold data and valid bits when adv = 0.
REQ-009 in_ready SHALL equal adv, combinationally; in_ready SHALL NOT depend on in_valid.
REQ-010 Latency SHALL be exactly S cycles from the input handshake to out_valid with no backpressure; throughput SHALL be one vector per cycle.
REQ-011 in_desc SHALL be captured with the vector and travel with it, so back-to-back vectors may use different orders.
REQ-012 Stall bubbles SHALL be preserved: a stage whose valid bit is 0 SHALL never produce out_valid.
REQ-013 out_data and out_tag SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-014 Data widths SHALL be exact; there SHALL be no truncation, sign extension or arithmetic beyond compare.

Reset
REQ-015 While rst = 1, all stage valid bits SHALL clear at the next clock edge; out_valid = 0 and in_ready = 1 from the first edge after reset onward.
REQ-016 Data and tag registers SHALL NOT need reset, but out_data SHALL read 0 after reset for deterministic simulation.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight vectors; no output handshake for them SHALL occur after reset.

Configuration
REQ-018 With macro SORT_TAG_EN defined:
- each element SHALL carry a log2(N)-bit tag initialised to its input lane index;
- tags SHALL swap together with their data;
- out_tag SHALL be driven.
REQ-019 Without SORT_TAG_EN, there SHALL be no out_tag port and no tag registers; data behaviour SHALL be identical.

Structure
REQ-020 Package sort_pkg SHALL hold:
- function sort_stages(N) returning S;
- function for the partner lane and direction of each (stage, lane);
- typedef for the element-plus-tag struct.
REQ-021 Sub-module cas_unit SHALL implement one combinational compare-and-swap with a direction input.
REQ-022 sort_pipe SHALL instantiate N/2 cas_unit per stage via generate, with registers between stages.

Verification
REQ-023 With N = 4 and DW = 8, input {lane0..3} = {9, 3, 200, 3}, in_desc = 0, out_ready = 1 -> after 3 cycles out = {3, 3, 9, 200}; with SORT_TAG_EN, tag = {1, 3, 0, 2}.
REQ-024 The same vector with in_desc = 1 -> out = {200, 9, 3, 3}.
REQ-025 Four back-to-back vectors with alternating in_desc and out_ready = 1 -> four out_valid cycles consecutively, each correctly ordered.
REQ-026 Hold out_ready = 0 for 5 cycles while feeding vectors -> at most S + 1 accepted, out_data stable, in_ready = 0; on release, no loss or duplication.
REQ-027 Assert rst for 1 cycle with 2 vectors in flight -> out_valid = 0 and no further outputs until new input arrives.
REQ-028 Run 10,000 random vectors, N = 16 and DW = 12, random in_valid/out_ready -> output matches the reference model's sort, in order.

Source files
------------

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - bitonic schedule helpers and element layout shared by sort_pipe and cas_unit
package sort_pkg;

    localparam int SORT_MAX_DW = 32;
    localparam int SORT_MAX_TW = 4;

    // Widest supported element; sort_pipe packs {tag, data} in this order at its own widths.
    typedef struct packed {
        logic [SORT_MAX_TW-1:0] tag;
        logic [SORT_MAX_DW-1:0] data;
    } sort_elem_t;

    function automatic int sort_stages(input int n);
        int l;
        l = $clog2(n);
        return l * (l + 1) / 2;
    endfunction

    // Merge block size k of flattened stage s (k = 2, 4, .., n; j = k/2 .. 1 within each k).
    function automatic int stage_k(input int n, input int s);
        int idx;
        int res;
        idx = 0;
        res = 2;
        for (int k = 2; k <= n; k = k * 2) begin
            for (int j = k / 2; j >= 1; j = j / 2) begin
                if (idx == s) res = k;
                idx = idx + 1;
            end
        end
        return res;
    endfunction

    function automatic int stage_j(input int n, input int s);
        int idx;
        int res;
        idx = 0;
        res = 1;
        for (int k = 2; k <= n; k = k * 2) begin
            for (int j = k / 2; j >= 1; j = j / 2) begin
                if (idx == s) res = j;
                idx = idx + 1;
            end
        end
        return res;
    endfunction

    function automatic int partner_lane(input int n, input int s, input int lane);
        return lane ^ stage_j(n, s);
    endfunction

    // Native direction for an ascending sort; the vector's own order flag inverts it.
    function automatic logic lane_desc(input int n, input int s, input int lane);
        return (lane & stage_k(n, s)) != 0;
    endfunction

endpackage

// File: rtl/cas_unit.sv
// rtl/cas_unit.sv - combinational compare-and-swap on the low DW bits of an EW-bit element
module cas_unit #(
    parameter int DW = 8,
    parameter int EW = 8
) (
    input  logic [EW-1:0] a_i,
    input  logic [EW-1:0] b_i,
    input  logic          desc_i,
    output logic [EW-1:0] lo_o,
    output logic [EW-1:0] hi_o
);

    logic swap;

    // Strict compares so equal keys never swap.
    assign swap = desc_i ? (a_i[DW-1:0] < b_i[DW-1:0]) : (a_i[DW-1:0] > b_i[DW-1:0]);
    assign lo_o = swap ? b_i : a_i;
    assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/sort_pipe.sv
// rtl/sort_pipe.sv - pipelined bitonic sorter; SORT_TAG_EN adds per-element lane tags and out_tag
module sort_pipe
    import sort_pkg::*;
#(
    parameter int DW = 8,
    parameter int N  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_desc,
    input  logic [N*DW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] out_data
`ifdef SORT_TAG_EN
    ,
    output logic [N*$clog2(N)-1:0] out_tag
`endif
);

    localparam int S = sort_stages(N);
`ifdef SORT_TAG_EN
    localparam int TW = $clog2(N);
    localparam int EW = DW + TW;
`else
    localparam int EW = DW;
`endif

    logic [EW-1:0] src   [S][N];
    logic [EW-1:0] cas_d [S][N];
    logic [EW-1:0] stg_q [S][N];
    logic [S-1:0]  vld_q;
    logic          desc_q [S];
    logic          stage_desc [S];
    logic          adv;

    assign adv       = !vld_q[S-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[S-1];

    for (genvar i = 0; i < N; i++) begin : g_lane
`ifdef SORT_TAG_EN
        assign src[0][i]              = {TW'(i), in_data[i*DW +: DW]};
        assign out_tag[i*TW +: TW]    = stg_q[S-1][i][EW-1:DW];
`else
        assign src[0][i]              = in_data[i*DW +: DW];
`endif
        assign out_data[i*DW +: DW]   = stg_q[S-1][i][DW-1:0];
    end

    for (genvar s = 0; s < S; s++) begin : g_stage
        localparam int J = stage_j(N, s);
        if (s == 0) begin : g_first
            assign stage_desc[s] = in_desc;
        end else begin : g_rest
            assign stage_desc[s] = desc_q[s-1];
            for (genvar i = 0; i < N; i++) begin : g_src
                assign src[s][i] = stg_q[s-1][i];
            end
        end
        for (genvar p = 0; p < N / 2; p++) begin : g_cas
            localparam int LO = (p / J) * 2 * J + (p % J);
            localparam int HI = partner_lane(N, s, LO);
            cas_unit #(.DW(DW), .EW(EW)) u_cas (
                .a_i    (src[s][LO]),
                .b_i    (src[s][HI]),
                .desc_i (stage_desc[s] ^ lane_desc(N, s, LO)),
                .lo_o   (cas_d[s][LO]),
                .hi_o   (cas_d[s][HI])
            );
        end
    end

    // Data is cleared too so out_data reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < S; s++) begin
                desc_q[s] <= 1'b0;
                for (int i = 0; i < N; i++) stg_q[s][i] <= '0;
            end
        end else if (adv) begin
            for (int s = 0; s < S; s++) begin
                vld_q[s]  <= (s == 0) ? in_valid : vld_q[(s == 0) ? 0 : s - 1];
                desc_q[s] <= stage_desc[s];
                for (int i = 0; i < N; i++) stg_q[s][i] <= cas_d[s][i];
            end
        end
    end

endmodule

// File: tb/tb_sort_pipe.sv
// tb/tb_sort_pipe.sv - self-checking bench: N=4/DW=8 directed cases, N=16/DW=12 random run
module tb_sort_pipe;

    localparam int AN  = 4;
    localparam int ADW = 8;
    localparam int AS  = 3;
    localparam int BN  = 16;
    localparam int BDW = 12;
    localparam int AW  = AN * ADW;
    localparam int BW  = BN * BDW;
    localparam int NUM = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_in_valid, a_in_ready, a_in_desc, a_out_valid, a_out_ready;
    logic [AW-1:0] a_in_data, a_out_data;
    logic          b_in_valid, b_in_ready, b_in_desc, b_out_valid, b_out_ready;
    logic [BW-1:0] b_in_data, b_out_data;
`ifdef SORT_TAG_EN
    logic [2*AN-1:0] a_out_tag;
    logic [4*BN-1:0] b_out_tag;
    logic [2*AN-1:0] a_tag_q[$];
`endif

    sort_pipe #(.DW(ADW), .N(AN)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_desc(a_in_desc), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef SORT_TAG_EN
        , .out_tag(a_out_tag)
`endif
    );

    sort_pipe #(.DW(BDW), .N(BN)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_desc(b_in_desc), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef SORT_TAG_EN
        , .out_tag(b_out_tag)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [BW-1:0] a_exp_q[$], a_got_q[$], b_exp_q[$], b_got_q[$];
    int            a_in_cyc_q[$], a_out_cyc_q[$];

    // Reference: unpack lanes, insertion sort, repack.
    function automatic logic [BW-1:0] ref_sort(input logic [BW-1:0] v, input int n, input int dw, input logic desc);
        int e[16];
        int t;
        int j;
        logic [BW-1:0] r;
        for (int i = 0; i < n; i++) e[i] = int'((v >> (i * dw)) & ((1 << dw) - 1));
        for (int i = 1; i < n; i++) begin
            j = i;
            while (j > 0 && (desc ? (e[j-1] < e[j]) : (e[j-1] > e[j]))) begin
                t = e[j]; e[j] = e[j-1]; e[j-1] = t;
                j = j - 1;
            end
        end
        r = '0;
        for (int i = 0; i < n; i++) r = r | (BW'(e[i]) << (i * dw));
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_in_valid && a_in_ready) begin
                a_exp_q.push_back(ref_sort(BW'(a_in_data), AN, ADW, a_in_desc));
                a_in_cyc_q.push_back(cyc);
            end
            if (a_out_valid && a_out_ready) begin
                a_got_q.push_back(BW'(a_out_data));
                a_out_cyc_q.push_back(cyc);
`ifdef SORT_TAG_EN
                a_tag_q.push_back(a_out_tag);
`endif
            end
            if (b_in_valid && b_in_ready) b_exp_q.push_back(ref_sort(b_in_data, BN, BDW, b_in_desc));
            if (b_out_valid && b_out_ready) b_got_q.push_back(b_out_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        a_exp_q.delete(); a_got_q.delete(); a_in_cyc_q.delete(); a_out_cyc_q.delete();
`ifdef SORT_TAG_EN
        a_tag_q.delete();
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_desc = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_desc = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_out_valid: got %b, required 0", a_out_valid); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_a_in_ready: got %b, required 1", a_in_ready); end
        n_cmp++; if (a_out_data !== '0) begin n_bad++; $display("FAIL reset_a_out_data: got %h, required 0", a_out_data); end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_out_valid: got %b, required 0", b_out_valid); end
        n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_b_in_ready: got %b, required 1", b_in_ready); end
        n_cmp++; if (b_out_data !== '0) begin n_bad++; $display("FAIL reset_b_out_data: got %h, required 0", b_out_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single(input logic desc, input logic [AW-1:0] exp);
        logic [BW-1:0] got;
        int lat;
        int waited;
        clear_a();
        a_in_data = {8'd3, 8'd200, 8'd3, 8'd9};
        a_in_desc = desc; a_in_valid = 1'b1; a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        waited = 0;
        while (a_got_q.size() == 0 && waited < 20) begin tick(); waited++; end
        n_cmp++;
        if (a_got_q.size() == 0 || a_in_cyc_q.size() == 0) begin
            n_bad++; $display("FAIL single_timeout desc=%0d: no output after %0d cycles, required one", desc, waited);
        end else begin
            got = a_got_q.pop_front();
            lat = a_out_cyc_q.pop_front() - a_in_cyc_q.pop_front();
            if (got !== BW'(exp)) begin n_bad++; $display("FAIL single_data desc=%0d: got %h, required %h", desc, got, exp); end
            n_cmp++;
            if (lat != AS) begin n_bad++; $display("FAIL single_latency desc=%0d: got %0d, required %0d", desc, lat, AS); end
`ifdef SORT_TAG_EN
            if (!desc) begin
                n_cmp++;
                if (a_tag_q.size() == 0 || a_tag_q[0] !== 8'b10_00_11_01) begin
                    n_bad++; $display("FAIL single_tag: got %b, required 10001101", (a_tag_q.size() == 0) ? 8'hx : a_tag_q[0]);
                end
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] got, exp;
        int oc, first;
        clear_a();
        a_out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            a_in_data = $urandom; a_in_desc = v[0]; a_in_valid = 1'b1;
            tick();
        end
        a_in_valid = 1'b0;
        repeat (AS + 4) tick();
        n_cmp++;
        if (a_got_q.size() != 4) begin n_bad++; $display("FAIL b2b_count: got %0d, required 4", a_got_q.size()); end
        first = 0;
        for (int v = 0; v < 4 && a_got_q.size() > 0 && a_exp_q.size() > 0; v++) begin
            got = a_got_q.pop_front(); exp = a_exp_q.pop_front(); oc = a_out_cyc_q.pop_front();
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL b2b_data #%0d: got %h, required %h", v, got, exp); end
            if (v == 0) first = oc;
            else begin
                n_cmp++;
                if (oc != first + v) begin n_bad++; $display("FAIL b2b_consecutive #%0d: got cycle %0d, required %0d", v, oc, first + v); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] held;
        logic held_valid;
        logic [BW-1:0] got, exp;
        int acc;
        clear_a();
        a_out_ready = 1'b0; a_in_valid = 1'b1; held_valid = 1'b0; held = '0;
        for (int c = 0; c < 5; c++) begin
            a_in_data = $urandom; a_in_desc = 1'($urandom_range(0, 1));
            tick();
            if (a_out_valid) begin
                if (!held_valid) begin held = a_out_data; held_valid = 1'b1; end
                else begin
                    n_cmp++;
                    if (a_out_data !== held) begin n_bad++; $display("FAIL bp_stable cycle %0d: got %h, required %h", c, a_out_data, held); end
                end
            end
        end
        acc = a_exp_q.size();
        n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b, required 0", a_in_ready); end
        n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b, required 1", a_out_valid); end
        n_cmp++; if (acc < 1 || acc > AS + 1) begin n_bad++; $display("FAIL bp_accepted: got %0d, required 1..%0d", acc, AS + 1); end
        n_cmp++; if (a_got_q.size() != 0) begin n_bad++; $display("FAIL bp_no_output: got %0d outputs, required 0", a_got_q.size()); end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (AS + 3) tick();
        n_cmp++;
        if (a_got_q.size() != acc) begin n_bad++; $display("FAIL bp_drain_count: got %0d, required %0d", a_got_q.size(), acc); end
        while (a_got_q.size() > 0 && a_exp_q.size() > 0) begin
            got = a_got_q.pop_front(); exp = a_exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL bp_drain_data: got %h, required %h", got, exp); end
        end
    endtask

    task automatic test_reset_midflight();
        int saw;
        logic [BW-1:0] got, exp;
        clear_a();
        a_out_ready = 1'b1; a_in_valid = 1'b1;
        a_in_data = $urandom; tick();
        a_in_data = $urandom; tick();
        a_in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        saw = a_out_valid ? 1 : 0;
        for (int c = 0; c < AS + 3; c++) begin tick(); if (a_out_valid) saw++; end
        n_cmp++; if (saw != 0) begin n_bad++; $display("FAIL rst_flight_valid: got %0d valid cycles, required 0", saw); end
        n_cmp++; if (a_got_q.size() != 0) begin n_bad++; $display("FAIL rst_flight_handshake: got %0d, required 0", a_got_q.size()); end
        clear_a();
        a_in_data = $urandom; a_in_desc = 1'b1; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        repeat (AS + 2) tick();
        n_cmp++;
        if (a_got_q.size() != 1 || a_exp_q.size() != 1) begin
            n_bad++; $display("FAIL rst_after_count: got %0d, required 1", a_got_q.size());
        end else begin
            got = a_got_q.pop_front(); exp = a_exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL rst_after_data: got %h, required %h", got, exp); end
        end
    endtask

    task automatic test_random();
        int sent, got_n, cycles;
        logic [BW-1:0] got, exp;
        b_exp_q.delete(); b_got_q.delete();
        sent = 0; got_n = 0; cycles = 0;
        while (got_n < NUM && cycles < 60000) begin
            b_in_valid = (sent < NUM) && ($urandom_range(0, 3) != 0);
            for (int i = 0; i < BN; i++)
                b_in_data[i*BDW +: BDW] = ($urandom_range(0, 3) == 0) ? BDW'($urandom_range(0, 3)) : BDW'($urandom_range(0, 4095));
            b_in_desc = 1'($urandom_range(0, 1));
            b_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b_in_valid && b_in_ready) sent++;
            tick();
            cycles++;
            while (b_got_q.size() > 0) begin
                got = b_got_q.pop_front(); got_n++;
                n_cmp++;
                if (b_exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rand_extra #%0d: got %h, required no output", got_n, got);
                end else begin
                    exp = b_exp_q.pop_front();
                    if (got !== exp) begin n_bad++; $display("FAIL rand_data #%0d: got %h, required %h", got_n, got, exp); end
                end
            end
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        n_cmp++;
        if (got_n != NUM || sent != NUM) begin
            n_bad++; $display("FAIL rand_count: got %0d out / %0d in, required %0d", got_n, sent, NUM);
        end
    endtask

    initial begin
        test_reset();
        test_single(1'b0, {8'd200, 8'd9, 8'd3, 8'd3});
        test_single(1'b1, {8'd3, 8'd3, 8'd9, 8'd200});
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
